result_serializer: RTL and testbench



---
 rtl/matrix_pkg.sv | 16 +
 rtl/result_serializer_if.sv | 24 ++
 rtl/result_serializer_elem_select.sv | 17 +
 rtl/result_serializer.sv | 109 ++++++++++
 tb/tb_result_serializer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared types and constants for the result serializer slice.
package matrix_pkg;
  localparam int ELEM_W = 16;
  localparam int N_ELEM = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, HDR, SEND_HI, SEND_LO} ser_state_t;
  typedef logic [3:0] elem_idx_t;

  // rows*cols in 8 bits, clamped to the number of slots on the result bus
  function automatic logic [7:0] clamp_count(input logic [3:0] rows, input logic [3:0] cols);
    logic [7:0] prod;
    prod = {4'd0, rows} * {4'd0, cols};
    return (prod > 8'(N_ELEM)) ? 8'(N_ELEM) : prod;
  endfunction
endpackage

// File: rtl/result_serializer_if.sv
// Capture-side and byte-stream signals of the result serializer.
interface result_serializer_if;
  import matrix_pkg::*;

  logic [ELEM_W*N_ELEM-1:0] res_mat;
  logic                     res_valid;
  logic [3:0]               rows;
  logic [3:0]               cols;
  logic                     busy;
  logic [BYTE_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (
    output res_mat, res_valid, rows, cols, out_ready,
    input  busy, out_data, out_valid, out_last
  );

  modport slave (
    input  res_mat, res_valid, rows, cols, out_ready,
    output busy, out_data, out_valid, out_last
  );
endinterface

// File: rtl/result_serializer_elem_select.sv
// Combinational 16:1 element mux; element 0 sits in the top bits of the bus.
module elem_select
  import matrix_pkg::*;
(
  input  logic [ELEM_W*N_ELEM-1:0] i_mat,
  input  elem_idx_t                i_idx,
  output logic [ELEM_W-1:0]        o_elem
);

  always_comb begin
    o_elem = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (i_idx == elem_idx_t'(i)) o_elem = i_mat[(N_ELEM-1-i)*ELEM_W +: ELEM_W];
    end
  end

endmodule

// File: rtl/result_serializer.sv
// Captures the result matrix and streams rows*cols elements as bytes, high byte first.
// Optional RESULT_SER_HEADER_EN prepends a {rows,cols} header byte.
//   state   | meaning
//   IDLE    | waiting for res_valid with a non-zero element count
//   HDR     | presenting the {rows,cols} header byte (header build only)
//   SEND_HI | presenting element[idx][15:8]
//   SEND_LO | presenting element[idx][7:0]
module result_serializer
  import matrix_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  result_serializer_if.slave s_bus
);

  ser_state_t               r_state;
  elem_idx_t                r_idx;
  elem_idx_t                r_last_idx;
  logic [ELEM_W*N_ELEM-1:0] r_mat;
  logic [BYTE_W-1:0]        r_out_data;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic                     r_busy;

  logic [7:0]               w_n;
  logic                     w_hs;
  elem_idx_t                w_sel_idx;
  logic [ELEM_W-1:0]        w_elem;

  assign w_n  = clamp_count(s_bus.rows, s_bus.cols);
  assign w_hs = r_out_valid && s_bus.out_ready;

  // Outputs are registered, so the mux looks one element ahead while in SEND_LO
  assign w_sel_idx = (r_state == SEND_LO) ? r_idx + 4'd1 : r_idx;

  elem_select u_elem_select (
    .i_mat  (r_mat),
    .i_idx  (w_sel_idx),
    .o_elem (w_elem)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_last_idx  <= '0;
      r_mat       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_bus.res_valid && (w_n != 8'd0)) begin
            r_mat       <= s_bus.res_mat;
            r_last_idx  <= elem_idx_t'(w_n - 8'd1);
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b1;
`ifdef RESULT_SER_HEADER_EN
            r_state     <= HDR;
            r_out_data  <= {s_bus.rows, s_bus.cols};
`else
            r_state     <= SEND_HI;
            r_out_data  <= s_bus.res_mat[ELEM_W*N_ELEM-1 -: BYTE_W];
`endif
          end
        end
        HDR: begin
          if (w_hs) begin
            r_state    <= SEND_HI;
            r_out_data <= w_elem[ELEM_W-1 -: BYTE_W];
          end
        end
        SEND_HI: begin
          if (w_hs) begin
            r_state    <= SEND_LO;
            r_out_data <= w_elem[BYTE_W-1:0];
            r_out_last <= (r_idx == r_last_idx);
          end
        end
        SEND_LO: begin
          if (w_hs) begin
            r_out_last <= 1'b0;
            if (r_idx == r_last_idx) begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_out_data  <= '0;
            end else begin
              r_state    <= SEND_HI;
              r_idx      <= r_idx + 4'd1;
              r_out_data <= w_elem[ELEM_W-1 -: BYTE_W];
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_bus.busy      = r_busy;
  assign s_bus.out_data  = r_out_data;
  assign s_bus.out_valid = r_out_valid;
  assign s_bus.out_last  = r_out_last;

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer; honours RESULT_SER_HEADER_EN when defined.
module tb_result_serializer;
  import matrix_pkg::*;

`ifdef RESULT_SER_HEADER_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  result_serializer_if sif ();

  result_serializer dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .s_bus (sif)
  );

  typedef struct {
    logic [7:0] d;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_popped = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic last);
    exp_t e;
    e.d = d;
    e.last = last;
    q.push_back(e);
  endtask

  task automatic push_hdr(input logic [3:0] rows, input logic [3:0] cols);
    if (HB == 1) push_exp({rows, cols}, 1'b0);
  endtask

  // Reference model: clamp count, then hi/lo bytes of each element in row-major order
  task automatic push_model(input logic [255:0] mat, input logic [3:0] rows, input logic [3:0] cols);
    int n;
    logic [15:0] el;
    n = int'(rows) * int'(cols);
    if (n > 16) n = 16;
    if (n == 0) return;
    push_hdr(rows, cols);
    for (int i = 0; i < n; i++) begin
      el = mat[255-16*i -: 16];
      push_exp(el[15:8], 1'b0);
      push_exp(el[7:0], i == n - 1);
    end
  endtask

  function automatic logic [255:0] mk_mat(input logic [15:0] base);
    logic [255:0] m;
    for (int i = 0; i < 16; i++) m[255-16*i -: 16] = base + 16'(i * 16'h0101);
    return m;
  endfunction

  // Caller is positioned just after a rising edge
  task automatic start_frame(input logic [255:0] mat, input logic [3:0] rows,
                             input logic [3:0] cols, input logic expect_start);
    sif.res_mat   = mat;
    sif.rows      = rows;
    sif.cols      = cols;
    sif.res_valid = 1'b1;
    @(posedge CLK);
    #1;
    sif.res_valid = 1'b0;
    check("latency_valid", sif.out_valid, expect_start);
    check("latency_busy", sif.busy, expect_start);
    sif.res_mat = ~mat;
    sif.rows    = 4'hF;
    sif.cols    = 4'hF;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((sif.busy || q.size() != 0) && k < budget) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check("idle_within_budget", k < budget, 1);
  endtask

  // Monitor: pops on every handshake and checks stability under backpressure
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", sif.out_valid, 1);
        check("stall_data_held", sif.out_data, prev_data);
        check("stall_last_held", sif.out_last, prev_last);
      end
      if (sif.out_valid && sif.out_ready) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_byte: got 0x%0h, required no byte", sif.out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("byte_data", sif.out_data, e.d);
          check("byte_last", sif.out_last, e.last);
        end
        n_popped++;
      end
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_data  = sif.out_data;
      prev_last  = sif.out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] m;
    int p0;

    RST_N         = 1'b0;
    sif.res_valid = 1'b0;
    sif.out_ready = 1'b1;
    sif.rows      = 4'd2;
    sif.cols      = 4'd2;
    sif.res_mat   = mk_mat(16'h1111);

    // Reset with res_valid toggling
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      sif.res_valid = ~sif.res_valid;
      check("rst_busy", sif.busy, 0);
      check("rst_valid", sif.out_valid, 0);
    end
    check("rst_data", sif.out_data, 0);
    check("rst_last", sif.out_last, 0);
    sif.res_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // 2x2 frame, hand-computed bytes, exact end-of-frame timing
    m = '0;
    m[255:192] = 64'h0102_0304_0506_0708;
    push_hdr(4'd2, 4'd2);
    push_exp(8'h01, 0); push_exp(8'h02, 0); push_exp(8'h03, 0); push_exp(8'h04, 0);
    push_exp(8'h05, 0); push_exp(8'h06, 0); push_exp(8'h07, 0); push_exp(8'h08, 1);
    start_frame(m, 4'd2, 4'd2, 1'b1);
    repeat (8 + HB - 1) @(posedge CLK);
    #1;
    check("f2x2_busy_before_last", sif.busy, 1);
    @(posedge CLK);
    #1;
    check("f2x2_busy_after", sif.busy, 0);
    check("f2x2_valid_after", sif.out_valid, 0);
    check("f2x2_all_consumed", q.size(), 0);

    // Backpressure on a 1x1 frame
    sif.out_ready = 1'b0;
    m = '0;
    m[255:240] = 16'hABCD;
    push_hdr(4'd1, 4'd1);
    push_exp(8'hAB, 0);
    push_exp(8'hCD, 1);
    start_frame(m, 4'd1, 4'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("bp_valid", sif.out_valid, 1);
      check("bp_data", sif.out_data, (HB == 1) ? 32'h11 : 32'hAB);
      @(posedge CLK);
      #1;
    end
    sif.out_ready = 1'b1;
    wait_idle(20);

    // Clamp: 5x5 streams 16 elements
    m = mk_mat(16'hA000);
    push_model(m, 4'd5, 4'd5);
    p0 = n_popped;
    start_frame(m, 4'd5, 4'd5, 1'b1);
    wait_idle(60);
    check("clamp_byte_count", n_popped - p0, 32 + HB);

    // Zero count: no capture
    start_frame(m, 4'd0, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("zero_valid", sif.out_valid, 0);
      check("zero_busy", sif.busy, 0);
    end

    // res_valid pulsed mid-frame is ignored
    m = mk_mat(16'h3C00);
    push_model(m, 4'd2, 4'd2);
    p0 = n_popped;
    start_frame(m, 4'd2, 4'd2, 1'b1);
    @(posedge CLK);
    #1;
    sif.res_mat   = mk_mat(16'hFFF0);
    sif.rows      = 4'd4;
    sif.cols      = 4'd4;
    sif.res_valid = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    sif.res_valid = 1'b0;
    wait_idle(30);
    check("ignored_byte_count", n_popped - p0, 8 + HB);
    repeat (3) @(posedge CLK);
    #1;
    check("ignored_no_recapture", sif.busy, 0);

    // Abort a 4x4 frame after three bytes with an asynchronous reset
    m = mk_mat(16'h7700);
    push_model(m, 4'd4, 4'd4);
    p0 = n_popped;
    start_frame(m, 4'd4, 4'd4, 1'b1);
    repeat (3) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("abort_valid", sif.out_valid, 0);
    check("abort_busy", sif.busy, 0);
    check("abort_bytes_before", n_popped - p0, 3);
    q.delete();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_stays_idle", sif.out_valid, 0);
    m = '0;
    m[255:240] = 16'h5AA5;
    push_hdr(4'd1, 4'd1);
    push_exp(8'h5A, 0);
    push_exp(8'hA5, 1);
    start_frame(m, 4'd1, 4'd1, 1'b1);
    wait_idle(20);

    // 2x3 frame: header byte 0x23 first in the header build
    m = mk_mat(16'h1200);
    push_model(m, 4'd2, 4'd3);
    p0 = n_popped;
    start_frame(m, 4'd2, 4'd3, 1'b1);
    wait_idle(40);
    check("f2x3_byte_count", n_popped - p0, 12 + HB);

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
